// File: rtl/dac_sample_feeder.sv
// Sample FIFO feeding the DAC data pins: one sample per DAC update strobe,
// with priming, underrun detection/counting and a mid-scale idle code.
module dac_sample_feeder #(
  parameter int                DATA_W     = 8,
  parameter int                DEPTH      = 16,
  parameter int                PRIME_LVL  = 8,
  parameter logic [DATA_W-1:0] IDLE_CODE  = 8'h80,
  parameter bit                HOLD_ON_UR = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [DATA_W-1:0]       s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic                    dac_stb,
  output logic [DATA_W-1:0]       dac_data,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    running,
  output logic                    underrun,
  output logic [15:0]             ur_count,
  input  logic                    ur_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] PRIME_L = LW'(PRIME_LVL);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [LW-1:0]     level_r;
  logic              full_r;
  state_t            state_r;
  logic [DATA_W-1:0] dac_data_r;
  logic              underrun_r;
  logic [15:0]       ur_count_r;

  logic              push_s;
  logic              pop_s;
  logic              ur_ev_s;
  logic [LW-1:0]     level_nxt_s;

  // Push/pop decode and next occupancy; pops only happen on a RUN strobe.
  always_comb begin
    push_s      = s_valid && !full_r;
    pop_s       = 1'b0;
    ur_ev_s     = 1'b0;
    level_nxt_s = level_r;
    if ((state_r == S_RUN) && dac_stb) begin
      if (level_r != {LW{1'b0}}) begin
        pop_s = 1'b1;
      end else begin
        ur_ev_s = 1'b1;
      end
    end else begin
      pop_s = 1'b0;
    end
    case ({push_s, pop_s})
      2'b10:   level_nxt_s = level_r + LW'(1);
      2'b01:   level_nxt_s = level_r - LW'(1);
      default: level_nxt_s = level_r;
    endcase
  end

  // Sample storage; contents are don't-care until the pointers cover them.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= s_data;
    end
  end

  // FIFO pointers, occupancy and registered full flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
      full_r   <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      level_r <= level_nxt_s;
      full_r  <= (level_nxt_s == DEPTH_L);
    end
  end

  // Control FSM and DAC output register; strobes act on the registered state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      dac_data_r <= IDLE_CODE;
      underrun_r <= 1'b0;
    end else begin
      underrun_r <= ur_ev_s;
      case (state_r)
        S_IDLE: begin
          if (dac_stb) begin
            dac_data_r <= IDLE_CODE;
          end
          if (enable) begin
            state_r <= S_PRIME;
          end
        end
        S_PRIME: begin
          if (dac_stb) begin
            dac_data_r <= IDLE_CODE;
          end
          if (!enable) begin
            state_r <= S_IDLE;
          end else if (level_r >= PRIME_L) begin
            state_r <= S_RUN;
          end
        end
        S_RUN: begin
          // On underrun with hold policy the register simply keeps the last sample.
          if (pop_s) begin
            dac_data_r <= mem_r[rd_ptr_r];
          end else if (ur_ev_s && !HOLD_ON_UR) begin
            dac_data_r <= IDLE_CODE;
          end
          if (!enable) begin
            state_r <= S_IDLE;
          end else if (ur_ev_s) begin
            state_r <= S_PRIME;
          end
        end
        default: begin
          state_r    <= S_IDLE;
          dac_data_r <= IDLE_CODE;
        end
      endcase
    end
  end

  // Saturating underrun counter; a clear still counts a coincident event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ur_count_r <= 16'd0;
    end else if (ur_clr) begin
      ur_count_r <= ur_ev_s ? 16'd1 : 16'd0;
    end else if (ur_ev_s && (ur_count_r != 16'hFFFF)) begin
      ur_count_r <= ur_count_r + 16'd1;
    end
  end

  assign s_ready  = !full_r;
  assign dac_data = dac_data_r;
  assign level    = level_r;
  assign running  = (state_r == S_RUN);
  assign underrun = underrun_r;
  assign ur_count = ur_count_r;

endmodule

// File: doc/dac_sample_feeder.md
Name: dac_sample_feeder

Overview:
- Upstream stage of the DAC output interface.
- Buffers samples from a producer (DDS, pattern generator, or host) in a small FIFO and presents one sample per DAC update strobe on dac_data.
- The strobe comes from the DAC clock generator: a one-clk pulse on the cycle where dac_clk is about to rise, i.e. the cycle that currently increments the ramp.
- Adds priming, underrun detection and an idle code, so the DAC never sees stale or garbage data.

Parameters:
- DATA_W, 8, sample width (matches DAC bus).
- DEPTH, 16, FIFO depth in samples; power of two, at least 4.
- PRIME_LVL, 8, FIFO level required before output starts; 1..DEPTH.
- IDLE_CODE, 8'h80, code driven when disabled or priming (mid-scale).
- HOLD_ON_UR, 1, underrun output policy: 1 = repeat last sample, 0 = drive IDLE_CODE.

Ports:
- clk  in  1  system clock (PLL c0 domain).
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  run request; level-sensitive.
- s_data  in  DATA_W  upstream sample.
- s_valid  in  1  upstream sample valid.
- s_ready  out  1  feeder can accept a sample this cycle.
- dac_stb  in  1  one-clk DAC update pulse from the clock generator.
- dac_data  out  DATA_W  registered sample to DAC data pins.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- running  out  1  high while in RUN.
- underrun  out  1  one-clk pulse on each underrun event.
- ur_count  out  16  saturating underrun event counter.
- ur_clr  in  1  synchronous clear of ur_count.

Behaviour:
Reset (rst_n low, asynchronous):
- FIFO emptied; level = 0; s_ready = 1.
- dac_data = IDLE_CODE; state = IDLE; running = 0; underrun = 0; ur_count = 0.

FIFO:
- Push when s_valid && s_ready. s_ready = !full, registered full flag.
- A push is not allowed when full, even if a pop occurs in the same cycle.
- Pop occurs only as described under RUN.
- Simultaneous push and pop when not full or empty: level unchanged.
- No bypass: a sample pushed in cycle N is poppable from cycle N+1.
- Pointers wrap modulo DEPTH. level never exceeds DEPTH.

State machine (IDLE, PRIME, RUN):
- IDLE:
  - dac_data is forced to IDLE_CODE on the next dac_stb.
  - FIFO keeps accepting pushes.
  - enable=1 moves to PRIME.
- PRIME:
  - No pops; dac_data updates to IDLE_CODE on dac_stb.
  - When level >= PRIME_LVL, move to RUN.
  - enable=0 returns to IDLE.
- RUN:
  - running = 1.
  - On dac_stb with level > 0: dac_data <= FIFO head, pop; 1-cycle latency from strobe to dac_data.
  - On dac_stb with level == 0: underrun pulse, ur_count increments, and state goes to PRIME. dac_data <= last sample if HOLD_ON_UR=1, else IDLE_CODE.
  - enable=0 moves to IDLE on the next cycle. Data already in the FIFO is retained, not flushed.
  - No dac_stb means no change to dac_data.

ur_count:
- Saturates at 16'hFFFF.
- ur_clr wins over a same-cycle underrun, but that event is still counted, so the result is 1.
- A plain ur_clr yields 0.

Other rules:
- dac_stb while in transition cycles acts per the current (registered) state.
- Reset asserted mid-operation discards all FIFO contents immediately.
- dac_stb pulses wider than one clk are undefined. Upstream guarantees single-cycle pulses at least 2 clks apart.

Test Plan:
- Reset check: after rst_n release, with no stimulus, dac_data=8'h80, s_ready=1, level=0, ur_count=0, running=0.
- Priming: enable=1, push 0x01..0x07, dac_stb every 10 clk. Output stays 0x80 and running=0. Push 0x08: running=1; the next strobes give dac_data 0x01,0x02,... one clk after each dac_stb.
- Full: with enable=0, push 16 samples. s_ready drops after the 16th; a 17th s_valid is not accepted; level=16. Enable and one strobe pop: s_ready returns 1 the next cycle.
- Underrun, HOLD_ON_UR=1: RUN with 2 samples (0x10,0x20) and 3 strobes gives dac_data 0x10, 0x20, then 0x20 again with underrun pulse, ur_count=1, state PRIME. HOLD_ON_UR=0 variant: third output is 0x80.
- Counter: force 65537 underruns and check ur_count=16'hFFFF. Then ur_clr coincident with an underrun gives ur_count=1.
- Mid-run reset: assert rst_n low while level=5 in RUN. Immediately dac_data=0x80 and level=0; after release, state is IDLE.
